// File: rtl/move_arbiter.sv
// Turns debounced button presses into one-at-a-time move commands for the board engine,
// with clear/abort handling, a move_done timeout, and a wait-for-release lockout.
module move_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_clr,
   output logic       move_valid,
   output logic [1:0] move_dir,
   input  logic       move_ready,
   input  logic       move_done,
   output logic       game_clear,
   output logic       busy,
   output logic       timeout_err
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_CLR   = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

   state_t          state, state_nxt;
   logic [4:0]      lvl, prev, edges;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            valid_nxt, clr_nxt, terr_nxt;
   logic [1:0]      dir_nxt, dir_pick;
   logic            any_dir;

   assign lvl   = {btn_clr, btn_right, btn_left, btn_down, btn_up};
   assign edges = lvl & ~prev;
   assign busy  = (state != IDLE);

   assign any_dir = |edges[B_RIGHT:B_UP];

   // Fixed priority: up > down > left > right; losers of a tie are dropped.
   always_comb begin
      dir_pick = 2'b11;
      if (edges[B_UP])        dir_pick = 2'b00;
      else if (edges[B_DOWN]) dir_pick = 2'b01;
      else if (edges[B_LEFT]) dir_pick = 2'b10;
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = move_valid;
      dir_nxt   = move_dir;
      clr_nxt   = 1'b0;
      terr_nxt  = timeout_err;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (edges[B_CLR]) begin
               clr_nxt   = 1'b1;
               terr_nxt  = 1'b0;
               state_nxt = RELEASE;
            end else if (any_dir) begin
               dir_nxt   = dir_pick;
               valid_nxt = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (edges[B_CLR]) begin
               valid_nxt = 1'b0;
               clr_nxt   = 1'b1;
               terr_nxt  = 1'b0;
               state_nxt = RELEASE;
            end else if (move_ready) begin
               valid_nxt = 1'b0;
               cnt_nxt   = '0;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // Counter saturates at CNT_LAST by leaving the state, so it never wraps.
            if (edges[B_CLR]) begin
               clr_nxt   = 1'b1;
               terr_nxt  = 1'b0;
               cnt_nxt   = '0;
               state_nxt = RELEASE;
            end else if (move_done) begin
               cnt_nxt   = '0;
               state_nxt = RELEASE;
            end else if (cnt == CNT_LAST) begin
               terr_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = RELEASE;
            end else begin
               cnt_nxt   = cnt + CW'(1);
            end
         end
         RELEASE: begin
            if (lvl == 5'b0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // prev loads all-ones in reset so buttons held across reset never look like a fresh press.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prev        <= '1;
         move_valid  <= 1'b0;
         move_dir    <= 2'b00;
         game_clear  <= 1'b0;
         timeout_err <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_nxt;
         prev        <= lvl;
         move_valid  <= valid_nxt;
         move_dir    <= dir_nxt;
         game_clear  <= clr_nxt;
         timeout_err <= terr_nxt;
         cnt         <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: inputs change and outputs are checked on the falling edge.
module tb_move_arbiter;

   localparam int TO = 8;

   logic       clk, rst;
   logic       btn_up, btn_down, btn_left, btn_right, btn_clr;
   logic       move_valid, move_ready, move_done, game_clear, busy, timeout_err;
   logic [1:0] move_dir;

   int checks = 0;
   int errors = 0;
   int issue_cnt = 0;
   int base;
   logic v_d = 1'b0;

   move_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_clr(btn_clr),
      .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
      .move_done(move_done), .game_clear(game_clear), .busy(busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts offered commands (rising edges of move_valid).
   always @(posedge clk) begin
      #2;
      if (move_valid && !v_d) issue_cnt++;
      v_d = move_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_clr = 0;
      move_ready = 0; move_done = 0;
      step(); step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", move_valid); end
      checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL reset_dir got %b exp 00", move_dir); end
      checks++; if (game_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b exp 0", game_clear); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b exp 0", timeout_err); end
      rst = 1'b0;
      step(); step();
   endtask

   task automatic test_single_left();
      base = issue_cnt;
      btn_left = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (move_valid !== 1'b1) begin errors++; $display("FAIL left_valid[%0d] got %b exp 1", i, move_valid); end
         checks++; if (move_dir !== 2'b10) begin errors++; $display("FAIL left_dir[%0d] got %b exp 10", i, move_dir); end
         if (i == 2) move_ready = 1;
      end
      step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL left_accept_valid got %b exp 0", move_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL left_wait_busy got %b exp 1", busy); end
      move_ready = 0;
      repeat (4) step();
      move_done = 1;
      step();
      move_done = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL left_release_busy got %b exp 1", busy); end
      btn_left = 0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL left_idle_busy got %b exp 0", busy); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL left_terr got %b exp 0", timeout_err); end
      checks++; if (move_dir !== 2'b10) begin errors++; $display("FAIL left_dir_hold got %b exp 10", move_dir); end
      checks++; if (issue_cnt - base !== 1) begin errors++; $display("FAIL left_issues got %0d exp 1", issue_cnt - base); end
   endtask

   task automatic test_priority();
      base = issue_cnt;
      btn_up = 1; btn_right = 1;
      step();
      checks++; if (move_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %b exp 1", move_valid); end
      checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL prio_dir got %b exp 00", move_dir); end
      move_ready = 1;
      step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL prio_accept got %b exp 0", move_valid); end
      move_ready = 0; move_done = 1;
      step();
      move_done = 0; btn_up = 0; btn_right = 0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy got %b exp 0", busy); end
      repeat (3) step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL prio_no_second got %b exp 0", move_valid); end
      checks++; if (issue_cnt - base !== 1) begin errors++; $display("FAIL prio_issues got %0d exp 1", issue_cnt - base); end
   endtask

   task automatic test_timeout();
      btn_down = 1;
      step();
      checks++; if (move_dir !== 2'b01) begin errors++; $display("FAIL to_dir got %b exp 01", move_dir); end
      move_ready = 1; btn_down = 0;
      step();
      move_ready = 0;
      for (int i = 0; i < TO - 1; i++) begin
         step();
         checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early[%0d] got %b exp 0", i, timeout_err); end
      end
      step();
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", timeout_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_release_busy got %b exp 1", busy); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle_busy got %b exp 0", busy); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
      btn_clr = 1;
      step();
      checks++; if (game_clear !== 1'b1) begin errors++; $display("FAIL to_clr_pulse got %b exp 1", game_clear); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_cleared got %b exp 0", timeout_err); end
      btn_clr = 0;
      step();
      checks++; if (game_clear !== 1'b0) begin errors++; $display("FAIL to_clr_single got %b exp 0", game_clear); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_clr_busy got %b exp 0", busy); end
   endtask

   task automatic test_abort();
      btn_right = 1;
      step();
      checks++; if (move_dir !== 2'b11) begin errors++; $display("FAIL abort_dir got %b exp 11", move_dir); end
      btn_clr = 1;
      step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", move_valid); end
      checks++; if (game_clear !== 1'b1) begin errors++; $display("FAIL abort_clr got %b exp 1", game_clear); end
      step();
      checks++; if (game_clear !== 1'b0) begin errors++; $display("FAIL abort_clr_single got %b exp 0", game_clear); end
      btn_right = 0;
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_held_busy got %b exp 1", busy); end
      btn_clr = 0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_held();
      btn_up = 1;
      step();
      checks++; if (move_valid !== 1'b1) begin errors++; $display("FAIL rh_issue got %b exp 1", move_valid); end
      rst = 1; btn_up = 0; btn_down = 1;
      step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL rh_rst_valid got %b exp 0", move_valid); end
      checks++; if (game_clear !== 1'b0) begin errors++; $display("FAIL rh_rst_clr got %b exp 0", game_clear); end
      rst = 0;
      step(); step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL rh_held_valid got %b exp 0", move_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rh_held_busy got %b exp 0", busy); end
      btn_down = 0;
      step();
      btn_down = 1;
      step();
      checks++; if (move_valid !== 1'b1) begin errors++; $display("FAIL rh_press_valid got %b exp 1", move_valid); end
      checks++; if (move_dir !== 2'b01) begin errors++; $display("FAIL rh_press_dir got %b exp 01", move_dir); end
      move_ready = 1; btn_down = 0;
      step();
      move_ready = 0; move_done = 1;
      step();
      move_done = 0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rh_end_busy got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      base = issue_cnt;
      btn_left = 1;
      step();
      move_ready = 1;
      step();
      move_ready = 0; btn_left = 0; btn_right = 1;
      step();
      btn_right = 0;
      step();
      btn_right = 1;
      step();
      move_done = 1;
      step();
      move_done = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_release_busy got %b exp 1", busy); end
      btn_right = 0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
      // Stray handshakes while idle must not start anything.
      move_ready = 1; move_done = 1;
      step();
      move_ready = 0; move_done = 0;
      repeat (3) step();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b exp 0", move_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stray_busy got %b exp 0", busy); end
      checks++; if (move_dir !== 2'b10) begin errors++; $display("FAIL b2b_dir_hold got %b exp 10", move_dir); end
      checks++; if (issue_cnt - base !== 1) begin errors++; $display("FAIL b2b_issues got %0d exp 1", issue_cnt - base); end
   endtask

   initial begin
      test_reset();
      test_single_left();
      step();
      test_priority();
      step();
      test_timeout();
      step();
      test_abort();
      step();
      test_reset_held();
      step();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
